// File: rtl/adder_result_pipe.sv
// adder_result_pipe: registered output stage behind the ripple-carry adder.
// Captures {carry, sum} into a two-entry skid buffer with a valid/ready
// handshake and counts delivered results that carried out (saturating).
module adder_result_pipe #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  sum,
  input  logic          carry,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N:0]    out_data,
  output logic [CW-1:0] carry_cnt,
  input  logic          cnt_clr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic [N:0]      main_q, main_d;
  logic [N:0]      skid_q, skid_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept;
  logic            deliver;
  logic [N:0]      new_res;

  assign accept   = in_valid & in_ready_q;
  assign deliver  = out_valid_q & out_ready;
  assign new_res  = {carry, sum};

  // Buffer occupancy transitions and data steering for main/skid.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = new_res;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          main_d = new_res;
        end else if (accept) begin
          skid_d  = new_res;
          state_d = ST_FULL;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the deliver side can move.
        if (deliver) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Handshake flags are decoded from the next state so both come out of flops.
  always_comb begin
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  // Carry-event counter: clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (deliver && main_q[N]) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // Control state, handshake flags, counter and the visible main register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      main_q      <= main_d;
      cnt_q       <= cnt_d;
    end
  end

  // Skid data is only observed after it is written, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign carry_cnt = cnt_q;

endmodule

// File: doc/adder_result_pipe.md
Name: adder_result_pipe

Overview:
- Registered output stage directly downstream of the N-bit ripple-carry adder. Captures the adder's sum and carry-out as one (N+1)-bit result {carry, sum}.
- Provides a valid/ready handshake with a 2-entry skid buffer, so the adder's consumer can stall without losing results.
- Keeps a saturating count of delivered results whose carry bit was set, for overflow monitoring.

Parameters:
N, 4, operand width of the adder feeding this stage; result width is N+1
CW, 8, width of the carry event counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  adder result on sum/carry is valid
in_ready  output  1  stage can accept a result this cycle
sum  input  N  sum output of the adder
carry  input  1  carry-out of the adder
out_valid  output  1  out_data holds a valid result
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  N+1  {carry, sum} of the oldest buffered result
carry_cnt  output  CW  saturating count of delivered results with carry=1
cnt_clr  input  1  synchronous clear of carry_cnt

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0: out_valid=0, in_ready=1, out_data=0, carry_cnt=0, and both buffer entries are invalid. The first accept can occur on the first rising edge after rst_n deasserts.
- Handshakes:
  - Accept: in_valid & in_ready at a rising edge.
  - Deliver: out_valid & out_ready at a rising edge.
  - in_valid is not required to be held when in_ready=0. The stage must not consume data while in_ready=0.
- Buffer: main register (drives out_data) plus skid register. States and behaviour at the clock edge:
  - EMPTY: out_valid=0, in_ready=1.
    - accept -> ONE; the result is written to main.
  - ONE: out_valid=1, in_ready=1.
    - accept & deliver -> ONE; main is replaced by the new result.
    - accept only -> FULL; the new result goes to skid.
    - deliver only -> EMPTY.
    - neither -> hold.
  - FULL: out_valid=1, in_ready=0.
    - deliver -> ONE; skid moves to main.
    - no deliver -> hold.
    - no accept is possible in FULL.
- Outputs are registered: in_ready and out_valid are register outputs, with no combinational path from out_ready to in_ready.
- Latency and throughput: a result accepted at edge k is on out_data with out_valid=1 during cycle k+1 (latency 1). Sustained throughput is 1 result per cycle when out_ready is held at 1.
- Ordering: strict FIFO; results are never dropped or duplicated.
- out_data holds its value while out_valid=1 and out_ready=0. Its value is don't-care (last value retained) when out_valid=0.
- carry_cnt:
  - Increments by 1 on each deliver where out_data[N]=1.
  - Saturates at 2^CW-1 and does not wrap.
  - Does not change on accept.
- cnt_clr=1 sets carry_cnt to 0 at the next edge. This has priority over a simultaneous increment: that event is lost.
- Reset mid-operation: all buffered results are discarded immediately and asynchronously, with outputs at the reset values above. carry_cnt also resets.
- Width rules: out_data = {carry, sum}, exactly N+1 bits with no extension. carry_cnt is unsigned, CW bits.

Test Plan:
- Reset and single pass (N=4): reset, then in_valid=1 for one cycle with sum=4'hA, carry=1, and out_ready=1 -> next cycle out_valid=1 and out_data=5'h1A; then out_valid=0; carry_cnt=1.
- Back-to-back streaming: out_ready=1, present sums 0..15 every cycle with carry=0 -> out_data=0..15 in order one cycle later, in_ready stays 1, carry_cnt stays 0.
- Backpressure and skid: out_ready=0, offer 5'h03 then 5'h15 then 5'h07 on consecutive cycles -> first two accepted, in_ready=0 in the third cycle, 5'h07 not taken. Then out_ready=1 -> delivers 5'h03, 5'h15, with in_ready back to 1 after the first deliver.
- Counter saturation (CW=2): deliver 5 results with carry=1 -> carry_cnt reads 1, 2, 3, 3, 3. Assert cnt_clr in the same cycle as a carry=1 deliver -> carry_cnt=0.
- Reset mid-operation: FULL state holding two results, pull rst_n low asynchronously mid-cycle -> out_valid=0, in_ready=1, carry_cnt=0 immediately. After release, the first new result is delivered alone with no stale data.
- Random stress: random in_valid/out_ready at 50% each for 2000 cycles against a scoreboard queue -> no loss, duplication, or reorder; carry_cnt matches the model.
